// File: rtl/mem_pkg.sv
// Shared definitions for the memory stage: funct3 encodings, FSM state type,
// access-size decode and the default bus timeout.
package mem_pkg;

  localparam int TIMEOUT_CYCLES_DEF = 16;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  typedef enum logic [1:0] {SZ_BYTE = 2'd0, SZ_HALF = 2'd1, SZ_WORD = 2'd2} acc_size_t;

  // Reserved encodings fall through to word access.
  function automatic acc_size_t access_size(input logic [2:0] f3);
    case (f3)
      F3_LB, F3_LBU: return SZ_BYTE;
      F3_LH, F3_LHU: return SZ_HALF;
      default:       return SZ_WORD;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Signal bundle for the memory stage: upstream handshake, data-memory bus and
// writeback. The stage itself connects through the slave modport.
interface mem_stage_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] Result;
  logic [31:0] mem_data_write;
  logic [2:0]  funct3;
  logic        mem_read;
  logic        mem_write;
  logic [4:0]  rd;
  logic        reg_write;

  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;

  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_reg_write;
  logic        bus_err;
  logic        misalign;

  modport master (
    output in_valid, Result, mem_data_write, funct3, mem_read, mem_write, rd, reg_write,
    output dmem_ack, dmem_rdata,
    input  in_ready, dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    input  wb_valid, wb_rd, wb_data, wb_reg_write, bus_err, misalign
  );

  modport slave (
    input  in_valid, Result, mem_data_write, funct3, mem_read, mem_write, rd, reg_write,
    input  dmem_ack, dmem_rdata,
    output in_ready, dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    output wb_valid, wb_rd, wb_data, wb_reg_write, bus_err, misalign
  );
endinterface

// File: rtl/mem_stage_load_align.sv
// Load formatter: picks the byte/half lane from the read word and sign- or
// zero-extends it according to funct3.
module load_align
  import mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  lane,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic signed [7:0]  byte_s;
  logic signed [15:0] half_s;

  always_comb begin
    case (lane)
      2'd0:    byte_s = $signed(rdata[7:0]);
      2'd1:    byte_s = $signed(rdata[15:8]);
      2'd2:    byte_s = $signed(rdata[23:16]);
      default: byte_s = $signed(rdata[31:24]);
    endcase
    half_s = lane[1] ? $signed(rdata[31:16]) : $signed(rdata[15:0]);

    case (funct3)
      F3_LB:   data = 32'(byte_s);
      F3_LH:   data = 32'(half_s);
      F3_LBU:  data = {24'd0, byte_s};
      F3_LHU:  data = {16'd0, half_s};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory stage: passes ALU results through in one cycle, runs loads/stores on a
// req/ack data bus with a timeout. Optional MISALIGN_CHECK_EN flags unaligned accesses.
module mem_stage
  import mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic     clk,
  input  logic     rst,
  mem_stage_if.slave bus
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_inc;
  logic             timeout, start_busy, done_ack, done_to;

  logic             dmem_req, dmem_we;
  logic [31:0]      dmem_addr, dmem_wdata;
  logic [3:0]       dmem_be;
  logic             wb_valid, wb_reg_write, bus_err, misalign;
  logic [4:0]       wb_rd;
  logic [31:0]      wb_data;

  logic [2:0]       funct3_p0;
  logic [4:0]       rd_p0;
  logic             reg_write_p0, is_store_p0;

  acc_size_t        size;
  logic [31:0]      addr_al, wdata_rep, load_data;
  logic [3:0]       be_calc;
  logic             is_mem, misaligned;

  // Request decode, alignment and lane replication
  always_comb begin
    size    = access_size(bus.funct3);
    is_mem  = bus.mem_read | bus.mem_write;
    addr_al = bus.Result;
    be_calc = 4'b1111;
    wdata_rep = bus.mem_data_write;
    case (size)
      SZ_BYTE: begin
        be_calc   = 4'b0001 << bus.Result[1:0];
        wdata_rep = {4{bus.mem_data_write[7:0]}};
      end
      SZ_HALF: begin
        addr_al   = {bus.Result[31:1], 1'b0};
        be_calc   = 4'b0011 << addr_al[1:0];
        wdata_rep = {2{bus.mem_data_write[15:0]}};
      end
      default: addr_al = {bus.Result[31:2], 2'b00};
    endcase
`ifdef MISALIGN_CHECK_EN
    misaligned = is_mem && (((size == SZ_HALF) && bus.Result[0]) ||
                            ((size == SZ_WORD) && (bus.Result[1:0] != 2'b00)));
`else
    misaligned = 1'b0;
`endif
  end

  assign cnt_inc = cnt + 1'b1;
  assign timeout = (cnt_inc == CNT_W'(TIMEOUT_CYCLES));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Ack takes precedence over timeout in the same cycle
  always_comb begin
    state_nxt  = state;
    start_busy = 1'b0;
    done_ack   = 1'b0;
    done_to    = 1'b0;
    case (state)
      IDLE: if (bus.in_valid && is_mem && !misaligned) begin
        state_nxt  = BUSY;
        start_busy = 1'b1;
      end
      BUSY: if (bus.dmem_ack) begin
        state_nxt = IDLE;
        done_ack  = 1'b1;
      end else if (timeout) begin
        state_nxt = IDLE;
        done_to   = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p0: instruction fields captured for the outstanding access
  always_ff @(posedge clk) begin
    if (start_busy) begin
      funct3_p0    <= bus.funct3;
      rd_p0        <= bus.rd;
      reg_write_p0 <= bus.reg_write & ~bus.mem_write;
      is_store_p0  <= bus.mem_write;
    end
  end

  load_align u_load_align (
    .rdata  (bus.dmem_rdata),
    .lane   (dmem_addr[1:0]),
    .funct3 (funct3_p0),
    .data   (load_data)
  );

  // Stage p1: bus drive and writeback registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      dmem_req <= 1'b0;
      dmem_we <= 1'b0;
      dmem_addr <= '0;
      dmem_wdata <= '0;
      dmem_be <= '0;
      wb_valid <= 1'b0;
      wb_rd <= '0;
      wb_data <= '0;
      wb_reg_write <= 1'b0;
      bus_err <= 1'b0;
      misalign <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      bus_err  <= 1'b0;
      misalign <= 1'b0;
      if (start_busy) begin
        cnt        <= '0;
        dmem_req   <= 1'b1;
        dmem_we    <= bus.mem_write;
        dmem_addr  <= addr_al;
        dmem_wdata <= wdata_rep;
        dmem_be    <= be_calc;
      end else if (state == IDLE && bus.in_valid) begin
        wb_valid <= 1'b1;
        wb_rd    <= bus.rd;
        if (misaligned) begin
          misalign     <= 1'b1;
          wb_reg_write <= 1'b0;
          wb_data      <= '0;
        end else begin
          wb_reg_write <= bus.reg_write;
          wb_data      <= bus.Result;
        end
      end
      if (done_ack) begin
        dmem_req     <= 1'b0;
        wb_valid     <= 1'b1;
        wb_rd        <= rd_p0;
        wb_reg_write <= reg_write_p0;
        wb_data      <= is_store_p0 ? 32'd0 : load_data;
      end else if (done_to) begin
        dmem_req     <= 1'b0;
        wb_valid     <= 1'b1;
        bus_err      <= 1'b1;
        wb_rd        <= rd_p0;
        wb_reg_write <= 1'b0;
        wb_data      <= '0;
      end else if (state == BUSY) begin
        cnt <= cnt_inc;
      end
    end
  end

  assign bus.in_ready     = (state == IDLE);
  assign bus.dmem_req     = dmem_req;
  assign bus.dmem_we      = dmem_we;
  assign bus.dmem_addr    = dmem_addr;
  assign bus.dmem_wdata   = dmem_wdata;
  assign bus.dmem_be      = dmem_be;
  assign bus.wb_valid     = wb_valid;
  assign bus.wb_rd        = wb_rd;
  assign bus.wb_data      = wb_data;
  assign bus.wb_reg_write = wb_reg_write;
  assign bus.bus_err      = bus_err;
  assign bus.misalign     = misalign;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: ALU pass-through, loads, stores, timeout,
// alignment (either build of MISALIGN_CHECK_EN) and reset during an access.
module tb_mem_stage;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  mem_stage_if bus ();

  mem_stage #(.TIMEOUT_CYCLES(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
  endtask

  task automatic issue(input logic [31:0] res, input logic [31:0] sdata, input logic [2:0] f3,
                       input logic rdv, input logic wrv, input logic [4:0] rdn, input logic rw);
    bus.in_valid       = 1'b1;
    bus.Result         = res;
    bus.mem_data_write = sdata;
    bus.funct3         = f3;
    bus.mem_read       = rdv;
    bus.mem_write      = wrv;
    bus.rd             = rdn;
    bus.reg_write      = rw;
    tick();
    bus.in_valid  = 1'b0;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.Result = '0;
    bus.mem_data_write = '0;
    bus.funct3 = '0;
    bus.mem_read = 1'b0;
    bus.mem_write = 1'b0;
    bus.rd = '0;
    bus.reg_write = 1'b0;
    bus.dmem_ack = 1'b0;
    bus.dmem_rdata = '0;
    tick();
    tick();

    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_req", bus.dmem_req, 0);
    chk("rst_wb_valid", bus.wb_valid, 0);
    chk("rst_wb_data", bus.wb_data, 0);
    chk("rst_wb_rd", bus.wb_rd, 0);
    chk("rst_be", bus.dmem_be, 0);
    chk("rst_addr", bus.dmem_addr, 0);
    rst = 1'b0;
    tick();

    // ALU pass-through
    issue(32'h1234, 32'h0, 3'b000, 1'b0, 1'b0, 5'd5, 1'b1);
    chk("alu_wb_valid", bus.wb_valid, 1);
    chk("alu_wb_data", bus.wb_data, 32'h1234);
    chk("alu_wb_rd", bus.wb_rd, 5);
    chk("alu_wb_rw", bus.wb_reg_write, 1);
    chk("alu_req", bus.dmem_req, 0);
    tick();
    chk("alu_wb_valid_drop", bus.wb_valid, 0);
    chk("alu_wb_data_hold", bus.wb_data, 32'h1234);

    // LB at 0x103, acked in the third request cycle
    issue(32'h103, 32'h0, 3'b000, 1'b1, 1'b0, 5'd7, 1'b1);
    chk("lb_req", bus.dmem_req, 1);
    chk("lb_in_ready", bus.in_ready, 0);
    chk("lb_be", bus.dmem_be, 4'b1000);
    chk("lb_addr", bus.dmem_addr, 32'h103);
    chk("lb_we", bus.dmem_we, 0);
    tick();
    chk("lb_wait_ready", bus.in_ready, 0);
    chk("lb_wait_req", bus.dmem_req, 1);
    tick();
    bus.dmem_ack = 1'b1;
    bus.dmem_rdata = 32'h80FF_FF00;
    tick();
    bus.dmem_ack = 1'b0;
    chk("lb_wb_valid", bus.wb_valid, 1);
    chk("lb_wb_data", bus.wb_data, 32'hFFFF_FF80);
    chk("lb_wb_rd", bus.wb_rd, 7);
    chk("lb_wb_rw", bus.wb_reg_write, 1);
    chk("lb_req_drop", bus.dmem_req, 0);
    chk("lb_ready_back", bus.in_ready, 1);

    // SH at 0x202, mem_read also high to exercise store priority
    issue(32'h202, 32'h1234_ABCD, 3'b001, 1'b1, 1'b1, 5'd3, 1'b1);
    chk("sh_be", bus.dmem_be, 4'b1100);
    chk("sh_wdata", bus.dmem_wdata, 32'hABCD_ABCD);
    chk("sh_we", bus.dmem_we, 1);
    chk("sh_addr", bus.dmem_addr, 32'h202);
    bus.dmem_ack = 1'b1;
    tick();
    bus.dmem_ack = 1'b0;
    chk("sh_wb_valid", bus.wb_valid, 1);
    chk("sh_wb_rw", bus.wb_reg_write, 0);

    // LHU and LH on upper half
    issue(32'h206, 32'h0, 3'b101, 1'b1, 1'b0, 5'd4, 1'b1);
    bus.dmem_ack = 1'b1;
    bus.dmem_rdata = 32'h8001_0000;
    tick();
    bus.dmem_ack = 1'b0;
    chk("lhu_wb_data", bus.wb_data, 32'h0000_8001);
    issue(32'h206, 32'h0, 3'b001, 1'b1, 1'b0, 5'd4, 1'b1);
    bus.dmem_ack = 1'b1;
    tick();
    bus.dmem_ack = 1'b0;
    chk("lh_wb_data", bus.wb_data, 32'hFFFF_8001);

    // SB at 0x301 replicates the byte
    issue(32'h301, 32'h0000_005A, 3'b000, 1'b0, 1'b1, 5'd2, 1'b1);
    chk("sb_be", bus.dmem_be, 4'b0010);
    chk("sb_wdata", bus.dmem_wdata, 32'h5A5A_5A5A);
    bus.dmem_ack = 1'b1;
    tick();
    bus.dmem_ack = 1'b0;

    // LW times out after 16 unacked request cycles
    issue(32'h40, 32'h0, 3'b010, 1'b1, 1'b0, 5'd9, 1'b1);
    for (int i = 0; i < 15; i++) tick();
    chk("to_req_cycle16", bus.dmem_req, 1);
    chk("to_no_wb_yet", bus.wb_valid, 0);
    tick();
    chk("to_req_drop", bus.dmem_req, 0);
    chk("to_wb_valid", bus.wb_valid, 1);
    chk("to_bus_err", bus.bus_err, 1);
    chk("to_wb_data", bus.wb_data, 0);
    chk("to_wb_rw", bus.wb_reg_write, 0);
    chk("to_ready", bus.in_ready, 1);
    tick();
    chk("to_bus_err_drop", bus.bus_err, 0);

    // Ack in the 16th cycle wins over timeout
    issue(32'h40, 32'h0, 3'b010, 1'b1, 1'b0, 5'd9, 1'b1);
    for (int i = 0; i < 15; i++) tick();
    bus.dmem_ack = 1'b1;
    bus.dmem_rdata = 32'hDEAD_BEEF;
    tick();
    bus.dmem_ack = 1'b0;
    chk("ack16_wb_valid", bus.wb_valid, 1);
    chk("ack16_bus_err", bus.bus_err, 0);
    chk("ack16_wb_data", bus.wb_data, 32'hDEAD_BEEF);
    chk("ack16_wb_rw", bus.wb_reg_write, 1);

    // LW at 0x101
    issue(32'h101, 32'h0, 3'b010, 1'b1, 1'b0, 5'd6, 1'b1);
`ifdef MISALIGN_CHECK_EN
    chk("mis_wb_valid", bus.wb_valid, 1);
    chk("mis_flag", bus.misalign, 1);
    chk("mis_wb_rw", bus.wb_reg_write, 0);
    chk("mis_no_req", bus.dmem_req, 0);
    chk("mis_ready", bus.in_ready, 1);
    tick();
    chk("mis_flag_drop", bus.misalign, 0);
`else
    chk("al_addr", bus.dmem_addr, 32'h100);
    chk("al_req", bus.dmem_req, 1);
    chk("al_misalign", bus.misalign, 0);
    bus.dmem_ack = 1'b1;
    bus.dmem_rdata = 32'h0BAD_F00D;
    tick();
    bus.dmem_ack = 1'b0;
    chk("al_wb_data", bus.wb_data, 32'h0BAD_F00D);
    chk("al_misalign_wb", bus.misalign, 0);
`endif

    // Reset two cycles into BUSY, with an ack landing in the reset cycle
    issue(32'h80, 32'h0, 3'b010, 1'b1, 1'b0, 5'd11, 1'b1);
    tick();
    rst = 1'b1;
    bus.dmem_ack = 1'b1;
    bus.dmem_rdata = 32'h1111_2222;
    tick();
    rst = 1'b0;
    bus.dmem_ack = 1'b0;
    chk("rstb_req", bus.dmem_req, 0);
    chk("rstb_ready", bus.in_ready, 1);
    chk("rstb_wb_valid", bus.wb_valid, 0);
    chk("rstb_wb_data", bus.wb_data, 0);
    tick();
    chk("rstb_wb_valid2", bus.wb_valid, 0);
    chk("rstb_req2", bus.dmem_req, 0);

    issue(32'hCAFE, 32'h0, 3'b000, 1'b0, 1'b0, 5'd12, 1'b0);
    chk("post_wb_data", bus.wb_data, 32'hCAFE);
    chk("post_wb_rw", bus.wb_reg_write, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
